// File: rtl/register_level0_ctrl.sv
// Burst initiator for the single-port level-0 register bank (cen_n/wen, registered read).
// Optional: define LEVEL0_CTRL_RANGE_CHECK_EN to reject out-of-range bursts with an err pulse.
module register_level0_ctrl #(
   parameter int data_width = 48,
   parameter int addr_width = 4,
   parameter int depth      = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [addr_width-1:0] cmd_addr,
   input  logic [addr_width:0]   cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [data_width-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [data_width-1:0] rd_data,
   output logic                  done,
   output logic                  err,
   output logic                  busy,
   output logic                  mem_cen_n,
   output logic                  mem_wen,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_din,
   input  logic [data_width-1:0] mem_dout
);
   localparam int len_width = addr_width + 1;
   localparam logic [len_width-1:0]  depth_len = len_width'(depth);
   localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   state_t state_q, state_d;

   logic [addr_width-1:0]      ptr_q, ptr_nxt, addr_eff;
   logic [len_width-1:0]       rem_q, len_eff;
   logic [2:0][data_width-1:0] fifo_q;
   logic [1:0]                 head_q, tail_q, occ_q;
   logic                       inflight_q, done_q;
   logic                       cmd_fire, rd_fire, issue, space, range_bad;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign rd_valid = (occ_q != 2'd0);
   assign rd_fire  = rd_valid && rd_ready;
   assign rd_data  = rd_valid ? fifo_q[head_q] : '0;
   assign done     = done_q;

   // Over-long bursts clamp to the bank size; start address folds into the bank.
   assign len_eff  = (cmd_len > depth_len) ? depth_len : cmd_len;
   assign addr_eff = addr_width'({1'b0, cmd_addr} % depth_len);
   assign ptr_nxt  = (ptr_q == last_addr) ? '0 : ptr_q + 1'b1;

   // Count the read in flight so a full buffer can always absorb the returning word.
   assign space = ({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3;

`ifdef LEVEL0_CTRL_RANGE_CHECK_EN
   logic [len_width:0] end_sum;
   logic               err_q;

   assign end_sum   = {2'b0, cmd_addr} + {1'b0, cmd_len};
   assign range_bad = ({1'b0, cmd_addr} >= depth_len) || (end_sum > {1'b0, depth_len});
   assign err       = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= cmd_fire && range_bad;
   end
`else
   assign range_bad = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      busy      = (state_q != IDLE);
      issue     = 1'b0;
      mem_cen_n = 1'b1;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && !range_bad && len_eff != '0)
               state_d = cmd_write ? WRITE : READ;
         end
         WRITE: begin
            wr_ready = (rem_q != '0);
            if (wr_valid && rem_q != '0) begin
               mem_cen_n = 1'b0;
               mem_wen   = 1'b1;
               mem_addr  = ptr_q;
               mem_din   = wr_data;
               if (rem_q == len_width'(1)) state_d = IDLE;
            end
         end
         READ: begin
            if (rem_q != '0 && space) begin
               issue     = 1'b1;
               mem_cen_n = 1'b0;
               mem_addr  = ptr_q;
            end
            if (rem_q == '0 && !inflight_q && occ_q == 2'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         occ_q      <= 2'd0;
         fifo_q     <= '0;
      end else begin
         // Zero-length bursts complete without ever leaving IDLE.
         done_q     <= (cmd_fire && !range_bad && len_eff == '0) ||
                       (state_q != IDLE && state_d == IDLE);
         inflight_q <= issue;
         if (cmd_fire) begin
            ptr_q <= addr_eff;
            rem_q <= len_eff;
         end else if (!mem_cen_n) begin
            ptr_q <= ptr_nxt;
            rem_q <= rem_q - 1'b1;
         end
         if (inflight_q) begin
            fifo_q[tail_q] <= mem_dout;
            tail_q         <= (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
         end
         if (rd_fire)
            head_q <= (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
         case ({inflight_q, rd_fire})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_register_level0_ctrl.sv
// Randomized bench for register_level0_ctrl: bank model, event monitor and per-burst reference checks.
module tb_register_level0_ctrl;
   localparam int dw = 48, aw = 4, depth = 10;

   logic          clk = 1'b0, rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [aw-1:0] cmd_addr;
   logic [aw:0]   cmd_len;
   logic          wr_valid, wr_ready, rd_valid, rd_ready;
   logic [dw-1:0] wr_data, rd_data, mem_din, mem_dout;
   logic          done, err, busy, mem_cen_n, mem_wen;
   logic [aw-1:0] mem_addr;

   always #5 clk = ~clk;

   register_level0_ctrl #(.data_width(dw), .addr_width(aw), .depth(depth)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .err(err), .busy(busy), .mem_cen_n(mem_cen_n), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout));

   // Level-0 bank: single port, registered read.
   logic [dw-1:0] bank [depth];
   always @(posedge clk)
      if (!mem_cen_n && mem_addr < aw'(depth)) begin
         if (mem_wen) bank[mem_addr] <= mem_din;
         else         mem_dout       <= bank[mem_addr];
      end

   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: append-only event logs, sampled mid-cycle.
   typedef struct {int cyc; logic [aw-1:0] addr; logic [dw-1:0] data;} ev_t;
   ev_t wlog[$], ilog[$], rlog[$];
   int  hs_log[$], done_log[$], err_log[$], rv_rise[$];
   int  cyc = 0, outst = 0, ovf = 0, idle_bad = 0, bad_addr = 0;
   bit  rv_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         outst   = 0;
         rv_prev = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) hs_log.push_back(cyc);
         if (!mem_cen_n) begin
            if (mem_addr >= aw'(depth)) bad_addr++;
            if (mem_wen) wlog.push_back('{cyc, mem_addr, mem_din});
            else begin
               ilog.push_back('{cyc, mem_addr, dw'(0)});
               outst++;
            end
         end else if (mem_wen || mem_addr != '0 || mem_din != '0) idle_bad++;
         if (rd_valid && rd_ready) begin
            rlog.push_back('{cyc, aw'(0), rd_data});
            outst--;
         end
         if (rd_valid && !rv_prev) rv_rise.push_back(cyc);
         rv_prev = rd_valid;
         if (outst > 3) ovf++;
         if (done) done_log.push_back(cyc);
         if (err) err_log.push_back(cyc);
      end
   end

   logic [dw-1:0] model [depth];

   // mode 0: wr_valid/rd_ready always 1; 1: rd_ready 1,0,0 pattern; 2: random.
   task automatic run_burst(input bit wr, input int addr, input int len, input int mode, input bit fixed);
      int eff, wb, ib, rb, db, eb, hb, ob, widx, to, h, a;
      bit bad_rng, acc;
      logic [dw-1:0] wdat[$];
      eff = (len > depth) ? depth : len;
      bad_rng = 1'b0;
`ifdef LEVEL0_CTRL_RANGE_CHECK_EN
      bad_rng = (addr >= depth) || (addr + len > depth);
`endif
      if (bad_rng) eff = 0;
      for (int i = 0; i < eff; i++)
         wdat.push_back(fixed ? dw'(10 + i) : dw'({$urandom(), $urandom()}));
      wb = wlog.size(); ib = ilog.size(); rb = rlog.size(); db = done_log.size();
      eb = err_log.size(); hb = hs_log.size(); ob = ovf;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = aw'(addr); cmd_len = (aw+1)'(len);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      widx = 0; to = 0;
      while (done_log.size() == db && err_log.size() == eb && to < 300) begin
         wr_valid = wr && widx < eff && (mode == 0 || $urandom_range(0, 3) != 0);
         wr_data  = (widx < eff) ? wdat[widx] : dw'($urandom());
         rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (to % 3 == 0) : 1'($urandom());
         @(negedge clk);
         acc = wr_valid && wr_ready;
         @(posedge clk); #1;
         if (acc) widx++;
         to++;
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("timeout", 64'(to < 300), 64'(1));
      chk("handshake", 64'(hs_log.size() - hb), 64'(1));
      h = hs_log[hb];
      chk("ovf", 64'(ovf - ob), 64'(0));
      if (bad_rng) begin
         chk("err_cnt", 64'(err_log.size() - eb), 64'(1));
         chk("err_cyc", 64'(err_log[eb]), 64'(h + 1));
         chk("err_done", 64'(done_log.size() - db), 64'(0));
         chk("err_acc", 64'(wlog.size() - wb + ilog.size() - ib), 64'(0));
         return;
      end
      chk("done_cnt", 64'(done_log.size() - db), 64'(1));
      chk("no_err", 64'(err_log.size() - eb), 64'(0));
      if (eff == 0) begin
         chk("len0_acc", 64'(wlog.size() - wb + ilog.size() - ib), 64'(0));
         chk("len0_done", 64'(done_log[db]), 64'(h + 1));
      end else if (wr) begin
         chk("w_cnt", 64'(wlog.size() - wb), 64'(eff));
         chk("w_no_rd", 64'(ilog.size() - ib), 64'(0));
         for (int i = 0; i < eff && wb + i < wlog.size(); i++) begin
            a = (addr + i) % depth;
            chk("w_addr", 64'(wlog[wb + i].addr), 64'(a));
            chk("w_data", 64'(wlog[wb + i].data), 64'(wdat[i]));
            model[a] = wdat[i];
         end
         chk("w_done_cyc", 64'(done_log[db]), 64'(wlog[wlog.size() - 1].cyc + 1));
         if (mode == 0) begin
            chk("w_first", 64'(wlog[wb].cyc), 64'(h + 1));
            chk("w_burst", 64'(wlog[wlog.size() - 1].cyc - wlog[wb].cyc), 64'(eff - 1));
         end
      end else begin
         chk("r_issue_cnt", 64'(ilog.size() - ib), 64'(eff));
         chk("r_beat_cnt", 64'(rlog.size() - rb), 64'(eff));
         chk("r_no_wr", 64'(wlog.size() - wb), 64'(0));
         for (int i = 0; i < eff && ib + i < ilog.size() && rb + i < rlog.size(); i++) begin
            a = (addr + i) % depth;
            chk("r_addr", 64'(ilog[ib + i].addr), 64'(a));
            chk("r_data", 64'(rlog[rb + i].data), 64'(model[a]));
         end
         if (rlog.size() > rb)
            chk("r_done_cyc", 64'(done_log[db]), 64'(rlog[rlog.size() - 1].cyc + 2));
         if (mode == 0 && rlog.size() > rb) begin
            chk("r_first_valid", 64'(rv_rise[rv_rise.size() - 1]), 64'(h + 3));
            chk("r_burst", 64'(rlog[rlog.size() - 1].cyc - rlog[rb].cyc), 64'(eff - 1));
         end
      end
   endtask

   task automatic reset_mid_read();
      int rb, db, to;
      rb = rlog.size(); db = done_log.size();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 5'd5; rd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      to = 0;
      while (rlog.size() - rb < 2 && to < 20) begin
         @(posedge clk); #1;
         to++;
      end
      chk("rst_two_beats", 64'(rlog.size() - rb), 64'(2));
      rst = 1'b1; #1;
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_cen_n", 64'(mem_cen_n), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", 64'(done_log.size() - db), 64'(0));
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_wr_ready", 64'(wr_ready), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cen_n", 64'(mem_cen_n), 64'(1));
      chk("rst_wen", 64'(mem_wen), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      chk("rst_din", 64'(mem_din), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      run_burst(1'b1, 0, depth, 0, 1'b0);  // fill so the model knows every entry
      run_burst(1'b1, 2, 4, 0, 1'b1);
      run_burst(1'b0, 2, 4, 0, 1'b0);
      run_burst(1'b0, 2, 4, 1, 1'b0);
      run_burst(1'b0, 3, 0, 0, 1'b0);
      run_burst(1'b1, 3, 0, 0, 1'b0);
      run_burst(1'b1, 8, 3, 2, 1'b0);
      run_burst(1'b0, 8, 3, 0, 1'b0);
      run_burst(1'b0, 0, 12, 0, 1'b0);
      run_burst(1'b0, 9, 10, 1, 1'b0);
      reset_mid_read();
      run_burst(1'b0, 1, 3, 0, 1'b0);
      for (int n = 0; n < 40; n++)
         run_burst(1'($urandom()), $urandom_range(0, depth - 1), $urandom_range(0, depth + 2),
                   $urandom_range(0, 2), 1'b0);

      chk("idle_port_quiet", 64'(idle_bad), 64'(0));
      chk("addr_in_bank", 64'(bad_addr), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
